// File: rtl/mac_tx_framer.sv
// XGMII transmit framer: wraps a keep/last byte-lane frame stream in Start/preamble/SFD and
// Terminate control characters, aborts on underrun or oversize, and enforces the inter-frame gap.
module mac_tx_framer #(
    parameter int N_LANES         = 8,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int IFG_BYTES       = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clk_en,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic [N_LANES*8-1:0] i_s_data,
    input  logic [N_LANES-1:0]   i_s_keep,
    input  logic                 i_s_last,
    output logic [N_LANES-1:0]   o_xgmii_ctrl,
    output logic [N_LANES*8-1:0] o_xgmii_data,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_underrun,
    output logic                 o_oversize,
    output logic                 o_runt
);

    localparam int CW  = $clog2(MAX_FRAME_BYTES + N_LANES) + 1;
    localparam int CW1 = CW + 1;
    localparam int GW  = $clog2(IFG_BYTES + N_LANES) + 1;
    localparam int GW1 = GW + 1;
    localparam int KW  = $clog2(N_LANES + 1);

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERR   = 8'hFE;
    localparam logic [7:0] C_PRE   = 8'h55;
    localparam logic [7:0] C_SFD   = 8'hD5;

    localparam logic [CW:0]          C_MAX       = CW1'(MAX_FRAME_BYTES);
    localparam logic [CW:0]          C_MIN       = CW1'(MIN_FRAME_BYTES);
    localparam logic [GW-1:0]        C_IFG       = GW'(IFG_BYTES);
    localparam logic [GW-1:0]        C_N         = GW'(N_LANES);
    localparam logic [GW-1:0]        C_NM1       = GW'(N_LANES - 1);
    localparam logic [N_LANES*8-1:0] C_IDLE_BEAT = {N_LANES{C_IDLE}};

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_PRE2, S_DATA, S_TERM, S_DROP, S_IFG
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_byte_cnt;
    logic [GW-1:0]          r_ifg_cnt;
    logic [N_LANES-1:0]     r_ctrl;
    logic [N_LANES*8-1:0]   r_data;
    logic                   r_done;
    logic                   r_under;
    logic                   r_over;
    logic                   r_runt;

    logic [KW-1:0]          w_keep_cnt;
    logic [CW:0]            w_byte_sum;
    logic [CW-1:0]          w_byte_next;
    logic [GW:0]            w_ifg_sum;
    logic [GW-1:0]          w_ifg_inc;
    logic [GW-1:0]          w_ifg_last;
    logic [N_LANES-1:0]     w_keep_sh;
    logic [N_LANES*8-1:0]   w_term_data;
    logic [N_LANES*8-1:0]   w_err_data;
    logic [N_LANES*8-1:0]   w_tlane0_data;
    logic [N_LANES*8-1:0]   w_pre_a;
    logic [N_LANES*8-1:0]   w_pre_b;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_keep_cnt    = '0;
        w_term_data   = '0;
        w_err_data    = '0;
        w_tlane0_data = '0;
        w_pre_a       = '0;
        w_pre_b       = '0;
        for (int j = 0; j < N_LANES; j++) begin
            w_keep_cnt = w_keep_cnt + KW'(i_s_keep[j]);
        end
        w_byte_sum  = {1'b0, r_byte_cnt} + CW1'(w_keep_cnt);
        w_byte_next = w_byte_sum[CW] ? '1 : w_byte_sum[CW-1:0];
        w_ifg_sum   = {1'b0, r_ifg_cnt} + GW1'(N_LANES);
        w_ifg_inc   = w_ifg_sum[GW] ? '1 : w_ifg_sum[GW-1:0];
        w_ifg_last  = C_N - GW'(w_keep_cnt);
        // Lane j carries /T/ when it is the first lane with keep low.
        w_keep_sh   = {i_s_keep[N_LANES-2:0], 1'b1};
        for (int j = 0; j < N_LANES; j++) begin
            w_term_data[j*8 +: 8]   = i_s_keep[j] ? i_s_data[j*8 +: 8]
                                                  : (w_keep_sh[j] ? C_TERM : C_IDLE);
            w_err_data[j*8 +: 8]    = (j == 0) ? C_ERR : ((j == 1) ? C_TERM : C_IDLE);
            w_tlane0_data[j*8 +: 8] = (j == 0) ? C_TERM : C_IDLE;
            w_pre_a[j*8 +: 8]       = (j == 0) ? C_START
                                    : ((N_LANES == 8 && j == N_LANES - 1) ? C_SFD : C_PRE);
            w_pre_b[j*8 +: 8]       = (j == N_LANES - 1) ? C_SFD : C_PRE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_ifg_cnt  <= '0;
            r_ctrl     <= '1;
            r_data     <= C_IDLE_BEAT;
            r_done     <= 1'b0;
            r_under    <= 1'b0;
            r_over     <= 1'b0;
            r_runt     <= 1'b0;
        end else if (i_clk_en) begin
            r_done  <= 1'b0;
            r_under <= 1'b0;
            r_over  <= 1'b0;
            r_runt  <= 1'b0;
            r_ctrl  <= '1;
            r_data  <= C_IDLE_BEAT;
            case (r_state)
                S_IDLE: begin
                    if (i_s_valid) r_state <= S_PRE;
                end
                S_PRE: begin
                    r_byte_cnt <= '0;
                    r_ctrl     <= N_LANES'(1);
                    r_data     <= w_pre_a;
                    r_state    <= (N_LANES == 8) ? S_DATA : S_PRE2;
                end
                S_PRE2: begin
                    r_ctrl  <= '0;
                    r_data  <= w_pre_b;
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    if (!i_s_valid) begin
                        r_data    <= w_err_data;
                        r_under   <= 1'b1;
                        r_ifg_cnt <= C_NM1;
                        r_state   <= S_DROP;
                    end else if (i_s_last) begin
                        r_byte_cnt <= w_byte_next;
                        if (&i_s_keep) begin
                            r_ctrl  <= '0;
                            r_data  <= i_s_data;
                            r_state <= S_TERM;
                        end else begin
                            r_ctrl    <= ~i_s_keep;
                            r_data    <= w_term_data;
                            r_done    <= 1'b1;
                            r_runt    <= (w_byte_sum < C_MIN);
                            r_ifg_cnt <= w_ifg_last;
                            r_state   <= (w_ifg_last >= C_IFG) ? S_IDLE : S_IFG;
                        end
                    end else if (w_byte_sum > C_MAX) begin
                        r_data    <= w_err_data;
                        r_over    <= 1'b1;
                        r_ifg_cnt <= C_NM1;
                        r_state   <= S_DROP;
                    end else begin
                        r_byte_cnt <= w_byte_next;
                        r_ctrl     <= '0;
                        r_data     <= i_s_data;
                    end
                end
                S_TERM: begin
                    r_data    <= w_tlane0_data;
                    r_done    <= 1'b1;
                    r_runt    <= ({1'b0, r_byte_cnt} < C_MIN);
                    r_ifg_cnt <= C_N;
                    r_state   <= (C_N >= C_IFG) ? S_IDLE : S_IFG;
                end
                S_DROP: begin
                    r_ifg_cnt <= w_ifg_inc;
                    if (i_s_valid && i_s_last) begin
                        r_state <= (w_ifg_inc >= C_IFG) ? S_IDLE : S_IFG;
                    end
                end
                S_IFG: begin
                    r_ifg_cnt <= w_ifg_inc;
                    if (w_ifg_inc >= C_IFG) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_s_ready    = (r_state == S_DATA) || (r_state == S_DROP);
    assign o_busy       = (r_state != S_IDLE);
    assign o_xgmii_ctrl = r_ctrl;
    assign o_xgmii_data = r_data;
    assign o_frame_done = r_done;
    assign o_underrun   = r_under;
    assign o_oversize   = r_over;
    assign o_runt       = r_runt;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Directed bench for mac_tx_framer: one 8-lane and one 4-lane instance sharing a beat-level
// stream source; each output beat is captured and compared against hand-computed XGMII values.
module tb_mac_tx_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, v, l;
    logic [63:0] d;
    logic [7:0]  k;
    int          sel;
    logic        v8, v4;
    assign v8 = v && (sel == 8);
    assign v4 = v && (sel == 4);

    logic        rdy8, busy8, done8, und8, ovs8, runt8;
    logic [7:0]  ctrl8;
    logic [63:0] data8;
    logic        rdy4, busy4, done4, und4, ovs4, runt4;
    logic [3:0]  ctrl4;
    logic [31:0] data4;

    mac_tx_framer #(.N_LANES(8)) u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_clk_en(ce),
        .i_s_valid(v8), .o_s_ready(rdy8), .i_s_data(d), .i_s_keep(k), .i_s_last(l),
        .o_xgmii_ctrl(ctrl8), .o_xgmii_data(data8), .o_busy(busy8),
        .o_frame_done(done8), .o_underrun(und8), .o_oversize(ovs8), .o_runt(runt8)
    );

    mac_tx_framer #(.N_LANES(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_clk_en(ce),
        .i_s_valid(v4), .o_s_ready(rdy4), .i_s_data(d[31:0]), .i_s_keep(k[3:0]), .i_s_last(l),
        .o_xgmii_ctrl(ctrl4), .o_xgmii_data(data4), .o_busy(busy4),
        .o_frame_done(done4), .o_underrun(und4), .o_oversize(ovs4), .o_runt(runt4)
    );

    logic        o_rdy, o_busy, o_done, o_und, o_ovs, o_runt;
    logic [7:0]  o_ctrl;
    logic [63:0] o_data;
    always_comb begin
        if (sel == 4) begin
            o_rdy = rdy4; o_busy = busy4; o_done = done4; o_und = und4; o_ovs = ovs4; o_runt = runt4;
            o_ctrl = {4'h0, ctrl4}; o_data = {32'h0, data4};
        end else begin
            o_rdy = rdy8; o_busy = busy8; o_done = done8; o_und = und8; o_ovs = ovs8; o_runt = runt8;
            o_ctrl = ctrl8; o_data = data8;
        end
    end

    localparam logic [63:0] IDLE8 = 64'h0707070707070707;
    localparam logic [63:0] IDLE4 = 64'h0000000007070707;
    localparam logic [63:0] EBEAT = 64'h070707070707FDFE;

    // Captured output beats (one entry per clk_en beat).
    logic [7:0]  c_ctrl [512];
    logic [63:0] c_data [512];
    bit          c_busy [512];
    bit          c_done [512];
    bit          c_und  [512];
    bit          c_ovs  [512];
    bit          c_runt [512];
    bit          c_rdy  [512];
    int          ncap;

    int fr_len [2];
    int nfr, f, b, gap_b;
    bit src_on, gapped;

    int n_eval = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit keep_legal(logic [7:0] kk, logic ll, int nl);
        logic [7:0] full;
        full = (nl == 8) ? 8'hFF : 8'h0F;
        if (kk == 8'h00 || (kk & ~full) != 8'h00) return 1'b0;
        if (((kk + 8'd1) & kk) != 8'h00) return 1'b0;
        if (!ll && kk != full) return 1'b0;
        return 1'b1;
    endfunction

    task automatic src_start(input int l0, input int l1, input int gapb);
        fr_len[0] = l0;
        fr_len[1] = l1;
        nfr       = (l1 > 0) ? 2 : 1;
        f         = 0;
        b         = 0;
        gap_b     = gapb;
        gapped    = 1'b0;
        src_on    = 1'b1;
        ncap      = 0;
    endtask

    task automatic drive();
        int rem;
        v = 1'b0; l = 1'b0; d = '0; k = '0;
        if (src_on) begin
            rem = fr_len[f] - b * sel;
            for (int j = 0; j < sel; j++) d[j*8 +: 8] = 8'(b * sel + j + 64 * f);
            if (rem > sel) k = (sel == 8) ? 8'hFF : 8'h0F;
            else begin
                k = 8'((1 << rem) - 1);
                l = 1'b1;
            end
            v = 1'b1;
            if (b == gap_b && !gapped && o_rdy) begin
                v      = 1'b0;
                gapped = 1'b1;
            end
        end
    endtask

    task automatic tick(input bit ce_v);
        bit acc;
        ce = ce_v;
        drive();
        if (v) begin
            n_eval++;
            assert (keep_legal(k, l, sel)) else begin
                n_fail++;
                $error("FAIL keep_legal: observed keep %h last %0d", k, l);
            end
        end
        acc = v && o_rdy && ce_v;
        @(posedge clk);
        #1;
        if (ce_v && ncap < 512) begin
            c_ctrl[ncap] = o_ctrl; c_data[ncap] = o_data; c_busy[ncap] = o_busy;
            c_done[ncap] = o_done; c_und[ncap]  = o_und;  c_ovs[ncap]  = o_ovs;
            c_runt[ncap] = o_runt; c_rdy[ncap]  = o_rdy;
            ncap++;
        end
        if (acc) begin
            if (l) begin
                f++;
                b = 0;
                if (f >= nfr) src_on = 1'b0;
            end else b++;
        end
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        src_on = 1'b0;
        tick(1'b1);
        tick(1'b1);
        rst    = 1'b0;
        ncap   = 0;
    endtask

    task automatic set_sel(input int s);
        sel = s;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    function automatic int find_start(int from);
        for (int i = from; i < ncap; i++)
            if (c_ctrl[i][0] && c_data[i][7:0] == 8'hFB) return i;
        return -1;
    endfunction

    function automatic int count_done(int lo, int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (c_done[i]) n++;
        return n;
    endfunction

    function automatic int count_ovs(int lo, int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (c_ovs[i]) n++;
        return n;
    endfunction

    initial begin
        rst = 1'b1; ce = 1'b0; v = 1'b0; l = 1'b0; d = '0; k = '0;
        sel = 8; src_on = 1'b0; ncap = 0; nfr = 0; f = 0; b = 0; gap_b = -1; gapped = 1'b0;

        // Reset state, both widths
        apply_reset();
        check("rst8_ctrl", 64'(o_ctrl), 64'hFF);
        check("rst8_data", o_data, IDLE8);
        check("rst8_ready", 64'(o_rdy), 64'd0);
        check("rst8_busy", 64'(o_busy), 64'd0);
        check("rst8_done", 64'(o_done), 64'd0);
        set_sel(4);
        check("rst4_ctrl", 64'(o_ctrl), 64'h0F);
        check("rst4_data", o_data, IDLE4);

        // N=8: two back-to-back 64-byte frames
        set_sel(8);
        apply_reset();
        src_start(64, 64, -1);
        run(30);
        check("a_idle0_ctrl", 64'(c_ctrl[0]), 64'hFF);
        check("a_pre_ctrl", 64'(c_ctrl[1]), 64'h01);
        check("a_pre_data", c_data[1], 64'hD5555555555555FB);
        check("a_d0_ctrl", 64'(c_ctrl[2]), 64'h00);
        check("a_d0_data", c_data[2], 64'h0706050403020100);
        check("a_d7_data", c_data[9], 64'h3F3E3D3C3B3A3938);
        check("a_term_ctrl", 64'(c_ctrl[10]), 64'hFF);
        check("a_term_data", c_data[10], 64'h07070707070707FD);
        check("a_term_done", 64'(c_done[10]), 64'd1);
        check("a_term_runt", 64'(c_runt[10]), 64'd0);
        check("a_early_done", 64'(count_done(0, 9)), 64'd0);
        check("a_ifg_busy", 64'(c_busy[11]), 64'd0);
        check("a_next_start", 64'(find_start(2)), 64'd13);
        check("a_f1_d0_data", c_data[14], 64'h4746454443424140);
        check("a_f1_done", 64'(c_done[22]), 64'd1);

        // N=8: 61-byte runt, Terminate in lane 5
        apply_reset();
        src_start(61, 0, -1);
        run(14);
        check("b_last_ctrl", 64'(c_ctrl[9]), 64'hE0);
        check("b_last_data", c_data[9], 64'h0707FD3C3B3A3938);
        check("b_done", 64'(c_done[9]), 64'd1);
        check("b_runt", 64'(c_runt[9]), 64'd1);
        check("b_ifg1_ctrl", 64'(c_ctrl[10]), 64'hFF);
        check("b_ifg1_busy", 64'(c_busy[10]), 64'd1);
        check("b_ifg2_busy", 64'(c_busy[11]), 64'd0);

        // N=4: two back-to-back 64-byte frames
        set_sel(4);
        apply_reset();
        src_start(64, 64, -1);
        run(30);
        check("c_idle0_ctrl", 64'(c_ctrl[0]), 64'h0F);
        check("c_idle0_data", c_data[0], IDLE4);
        check("c_pre1_ctrl", 64'(c_ctrl[1]), 64'h01);
        check("c_pre1_data", c_data[1], 64'h00000000555555FB);
        check("c_pre2_ctrl", 64'(c_ctrl[2]), 64'h00);
        check("c_pre2_data", c_data[2], 64'h00000000D5555555);
        check("c_d0_data", c_data[3], 64'h0000000003020100);
        check("c_d15_data", c_data[18], 64'h000000003F3E3D3C);
        check("c_term_ctrl", 64'(c_ctrl[19]), 64'h0F);
        check("c_term_data", c_data[19], 64'h00000000070707FD);
        check("c_term_done", 64'(c_done[19]), 64'd1);
        check("c_ifg1_busy", 64'(c_busy[20]), 64'd1);
        check("c_ifg2_busy", 64'(c_busy[21]), 64'd0);
        check("c_next_start", 64'(find_start(3)), 64'd23);

        // N=8: underrun at DATA beat 3 of a 128-byte frame, then a 64-byte frame
        set_sel(8);
        apply_reset();
        src_start(128, 64, 3);
        run(40);
        check("d_d2_data", c_data[4], 64'h1716151413121110);
        check("d_err_ctrl", 64'(c_ctrl[5]), 64'hFF);
        check("d_err_data", c_data[5], EBEAT);
        check("d_err_pulse", 64'(c_und[5]), 64'd1);
        check("d_drop_ready", 64'(c_rdy[5]), 64'd1);
        check("d_drop_busy", 64'(c_busy[17]), 64'd1);
        check("d_drain_idle", 64'(c_busy[18]), 64'd0);
        check("d_no_done", 64'(count_done(0, 28)), 64'd0);
        check("d_next_start", 64'(find_start(6)), 64'd20);
        check("d_f1_done", 64'(c_done[29]), 64'd1);

        // N=8: 1600-byte frame exceeds MAX_FRAME_BYTES at beat 190
        apply_reset();
        src_start(1600, 0, -1);
        run(210);
        check("e_b188_ctrl", 64'(c_ctrl[190]), 64'h00);
        check("e_b188_data", c_data[190], 64'hE7E6E5E4E3E2E1E0);
        check("e_err_ctrl", 64'(c_ctrl[191]), 64'hFF);
        check("e_err_data", c_data[191], EBEAT);
        check("e_ovs_pulse", 64'(c_ovs[191]), 64'd1);
        check("e_ovs_count", 64'(count_ovs(0, 209)), 64'd1);
        check("e_no_done", 64'(count_done(0, 209)), 64'd0);
        check("e_drop_busy", 64'(c_busy[200]), 64'd1);
        check("e_drop_end", 64'(c_busy[201]), 64'd0);

        // N=8: 64-byte frame with clk_en toggling every cycle
        apply_reset();
        src_start(64, 0, -1);
        for (int i = 0; i < 30; i++) tick(i % 2 == 0);
        check("f_pre_data", c_data[1], 64'hD5555555555555FB);
        check("f_d0_data", c_data[2], 64'h0706050403020100);
        check("f_d7_data", c_data[9], 64'h3F3E3D3C3B3A3938);
        check("f_term_data", c_data[10], 64'h07070707070707FD);
        check("f_term_done", 64'(c_done[10]), 64'd1);
        check("f_done_once", 64'(count_done(0, 14)), 64'd1);
        check("f_ifg_busy", 64'(c_busy[11]), 64'd0);

        // N=8: reset asserted mid-DATA
        apply_reset();
        src_start(64, 0, -1);
        run(5);
        check("g_in_data", 64'(c_rdy[4]), 64'd1);
        rst = 1'b1;
        tick(1'b1);
        rst    = 1'b0;
        src_on = 1'b0;
        check("g_rst_ctrl", 64'(c_ctrl[5]), 64'hFF);
        check("g_rst_data", c_data[5], IDLE8);
        check("g_rst_ready", 64'(c_rdy[5]), 64'd0);
        check("g_rst_busy", 64'(c_busy[5]), 64'd0);
        tick(1'b1);
        check("g_after_data", c_data[6], IDLE8);
        check("g_after_done", 64'(c_done[6]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
